mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal values 8..64, even only.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: resetn  in  1  reset, synchronous, active-low.
REQ-004 Port: start  in  1  request; sampled only in IDLE.
REQ-005 Port: op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others are no-op.
REQ-006 Port: src_a  in  WIDTH  multiplicand / dividend / MTHI-MTLO data.
REQ-007 Port: src_b  in  WIDTH  multiplier / divisor.
REQ-008 Port: flush  in  1  abort in-flight operation.
REQ-009 Port: busy  out  1  high while in CALC or DONE.
REQ-010 Port: done  out  1  one-cycle pulse in DONE.
REQ-011 Port: stall_req  out  1  = busy OR (start AND op in {MULT, MULTU, DIV, DIVU} AND NOT flush); drives stallF/stallD of the pipeline.
REQ-012 Port: hi  out  WIDTH  HI register (product upper half / remainder).
REQ-013 Port: lo  out  WIDTH  LO register (product lower half / quotient).

Function
REQ-014 FSM states: IDLE, CALC, DONE; encoding is free.
REQ-015 IDLE + start + mul/div op + !flush: latch operands, op and operand signs; load iteration counter = WIDTH; go to CALC.
REQ-016 IDLE + start + MTHI (MTLO) + !flush: hi (lo) <= src_a at that edge; stay in IDLE; no busy, no done.
REQ-017 CALC: one radix-2 step per cycle (shift-add multiply, restoring divide) on magnitudes; counter decrements; at counter = 1 go to DONE.
REQ-018 DONE: hi/lo updated at the entering edge; done = 1 for exactly this cycle; unconditional return to IDLE.
REQ-019 Latency: start sampled at edge t -> done high in cycle after edge t+WIDTH+1 -> hi/lo valid from edge t+WIDTH+1; next start accepted in the cycle after DONE.
REQ-020 Signed ops: results use operand magnitudes; product is negated when signs differ; quotient is negated when signs differ; remainder takes dividend sign.
REQ-021 MULT/MULTU: {hi, lo} = full 2*WIDTH-bit product.
REQ-022 DIV/DIVU: lo = quotient, hi = remainder; truncation toward zero.
REQ-023 Divisor zero (DIV/DIVU): lo = all ones, hi = src_a as latched; same latency; no error flag.
REQ-024 DIV with dividend = most-negative and divisor = -1: lo = most-negative, hi = 0.
REQ-025 start while busy: ignored; latched operands are unaffected.
REQ-026 flush in CALC or DONE: next state IDLE; hi/lo keep pre-operation values; no done pulse is issued, including when flush coincides with the final CALC cycle.
REQ-027 flush with start in IDLE: start is ignored, including MTHI/MTLO.
REQ-028 Undefined op codes with start: no state change.
REQ-029 Input changes on src_a/src_b after acceptance: no effect on the result.

Reset
REQ-030 resetn low at a rising edge: state = IDLE, hi = 0, lo = 0, counter = 0, busy = 0, done = 0, regardless of current state (mid-operation included).
REQ-031 stall_req during reset = combinational from inputs with busy = 0; pipeline ignores it while resetn low.

Verification
REQ-032 WIDTH=32, MULT src_a=0xFFFFFFFD (-3), src_b=7 -> done exactly 33 cycles after accept edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; DIVU 100/7 -> lo=14, hi=2.
REQ-034 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234, done at cycle 33.
REQ-036 MTLO 0x55 -> lo=0x55 next edge, busy never high; then MULT started and flushed at cycle 10 -> no done, lo stays 0x55, new start accepted in the next cycle.
REQ-037 resetn low at cycle 20 of a DIV -> hi=lo=0, busy=0 on the following cycle; start is ignored in the idle cycle after reset release only if flush is high.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply
// and restoring divide on operand magnitudes, one step per clock.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   hi_bak_q, lo_bak_q;
  logic [2*WIDTH-1:0] p_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               is_div_q;
  logic               neg_q_q;
  logic               neg_r_q;
  logic               div_zero_q;

  // Operation decode and operand magnitudes, evaluated at acceptance.
  logic             op_muldiv, op_is_div, op_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a_in, mag_b_in;

  assign op_muldiv = (op[2] == 1'b0);
  assign op_is_div = (op[2:1] == 2'b01);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = op_signed & src_a[WIDTH-1];
  assign b_neg     = op_signed & src_b[WIDTH-1];
  assign mag_a_in  = a_neg ? -src_a : src_a;
  assign mag_b_in  = b_neg ? -src_b : src_b;

  // p_q holds {product-high, multiplier} for multiply, {remainder, quotient} for divide.
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] p_d, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, hi_d, lo_d;

  always_comb begin
    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mag_b_q} : {(WIDTH+1){1'b0}});
    div_shift = p_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mag_b_q};
    div_ge    = (div_shift >= {1'b0, mag_b_q});
    p_d       = {mul_sum, p_q[WIDTH-1:1]};
    if (is_div_q) begin
      if (div_ge) begin
        p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
      end else begin
        p_d = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
      end
    end

    prod_fix = neg_q_q ? -p_q : p_q;
    quot_fix = neg_q_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem_fix  = neg_r_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
    lo_d     = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        hi_d = a_raw_q;
        lo_d = {WIDTH{1'b1}};
      end else begin
        hi_d = rem_fix;
        lo_d = quot_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      hi_bak_q   <= '0;
      lo_bak_q   <= '0;
      p_q        <= '0;
      mag_b_q    <= '0;
      a_raw_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start && !flush) begin
            if (op_muldiv) begin
              state_q    <= S_CALC;
              busy_q     <= 1'b1;
              cnt_q      <= CW'(WIDTH);
              p_q        <= {{WIDTH{1'b0}}, mag_a_in};
              mag_b_q    <= mag_b_in;
              a_raw_q    <= src_a;
              is_div_q   <= op_is_div;
              neg_q_q    <= a_neg ^ b_neg;
              neg_r_q    <= a_neg;
              div_zero_q <= (src_b == '0);
              hi_bak_q   <= hi_q;
              lo_bak_q   <= lo_q;
            end else if (op == OP_MTHI) begin
              hi_q <= src_a;
            end else if (op == OP_MTLO) begin
              lo_q <= src_a;
            end
          end
        end
        S_CALC: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            p_q   <= p_d;
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // All steps done: apply sign correction and publish in the same edge.
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (flush) begin
            hi_q <= hi_bak_q;
            lo_q <= lo_bak_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  // busy is masked during reset so the request reflects only the live inputs.
  assign stall_req = (busy_q & resetn) | (start & op_muldiv & ~flush);

endmodule

// File: tb/tb_mdu_iter.sv
// Directed testbench for mdu_iter (WIDTH=32): latency, signed/unsigned results,
// divide-by-zero, overflow case, MTHI/MTLO, flush and reset behaviour.
module tb_mdu_iter;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  mdu_iter #(.WIDTH(32)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one mul/div op, disturb inputs, wait for done and check latency/result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cycles;
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick;
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    src_a = $urandom;
    src_b = $urandom;
    cycles = 0;
    while (!done && cycles < 100) begin
      if (cycles == 4) begin
        start = 1'b1;
        op    = MULTU;
      end else begin
        start = 1'b0;
      end
      tick;
      cycles++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(cycles), 64'd33);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h after %0d cycles", tag, o, a, b, hi, lo, cycles);
    tick;
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    int  cycles;
    logic seen_done;

    resetn = 1'b0; start = 1'b0; op = MULT; src_a = '0; src_b = '0; flush = 1'b0;
    tick; tick;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    resetn = 1'b1;
    tick;

    // MTHI together with flush is dropped.
    start = 1'b1; op = MTHI; src_a = 32'hAA; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    check("mthi_flush_hi", 64'(hi), 64'd0);

    // MTLO writes lo at the next edge and never stalls or goes busy.
    start = 1'b1; op = MTLO; src_a = 32'h55;
    #1;
    check("mtlo_stall", 64'(stall_req), 64'd0);
    tick;
    start = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h55);
    check("mtlo_busy", 64'(busy), 64'd0);
    $display("[TB] mtlo lo=%h", lo);

    // stall_req is combinational on start/op/flush in IDLE.
    start = 1'b1; op = MULT; flush = 1'b0;
    #1;
    check("stall_start", 64'(stall_req), 64'd1);
    flush = 1'b1;
    #1;
    check("stall_flush", 64'(stall_req), 64'd0);
    flush = 1'b0;

    // MULT flushed in its tenth cycle: no done, hi/lo untouched.
    src_a = 32'd3; src_b = 32'd5;
    tick;
    start = 1'b0;
    seen_done = 1'b0;
    for (int i = 1; i < 10; i++) begin
      tick;
      seen_done = seen_done | done;
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    seen_done = seen_done | done;
    check("flush10_done", 64'(seen_done), 64'd0);
    check("flush10_busy", 64'(busy), 64'd0);
    check("flush10_lo", 64'(lo), 64'h55);
    check("flush10_hi", 64'(hi), 64'd0);
    $display("[TB] flush at cycle 10 busy=%b lo=%h", busy, lo);

    // New start accepted immediately in the following cycle.
    run_op("mult_neg3x7", MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_m7_2", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_min_m1", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu_by0", DIVU, 32'h1234, 32'd0, 32'h00001234, 32'hFFFFFFFF);
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op("div_neg_by0", DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
    run_op("mult_carry", MULT, 32'h40000000, 32'd4, 32'd1, 32'd0);

    // Flush during the last CALC cycle suppresses done and the hi/lo update.
    start = 1'b1; op = DIVU; src_a = 32'd100; src_b = 32'd7;
    tick;
    start = 1'b0;
    repeat (32) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flushlast_done", 64'(done), 64'd0);
    check("flushlast_busy", 64'(busy), 64'd0);
    check("flushlast_hi", 64'(hi), 64'd1);
    check("flushlast_lo", 64'(lo), 64'd0);
    $display("[TB] flush on final step done=%b hi=%h lo=%h", done, hi, lo);

    // Flush in DONE restores the pre-operation hi/lo.
    start = 1'b1; op = MULTU; src_a = 32'd3; src_b = 32'd5;
    tick;
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 100) begin
      tick;
      cycles++;
    end
    check("flushdone_lat", 64'(cycles), 64'd33);
    check("flushdone_res", 64'(lo), 64'd15);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flushdone_hi", 64'(hi), 64'd1);
    check("flushdone_lo", 64'(lo), 64'd0);
    check("flushdone_busy", 64'(busy), 64'd0);
    $display("[TB] flush in done hi=%h lo=%h", hi, lo);

    // Reset in cycle 20 of a DIV.
    start = 1'b1; op = DIV; src_a = 32'd100; src_b = 32'd7;
    tick;
    start = 1'b0;
    repeat (19) tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    $display("[TB] reset mid-div hi=%h lo=%h busy=%b", hi, lo, busy);
    start = 1'b1; op = DIVU; src_a = 32'd100; src_b = 32'd7; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    check("postrst_flush_busy", 64'(busy), 64'd0);
    run_op("postrst_divu", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
